// File: rtl/fpu_pkg.sv
// Shared single-precision field layout and special encodings for the FPU datapath units.
package fpu_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int EMIN   = -126;

  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
  localparam logic [31:0]      CANON_NAN = 32'hFFC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
endpackage

// File: rtl/fp_unpack.sv
// Combinational field extraction and operand classification for a binary32 word.
module fp_unpack import fpu_pkg::*; (
  input  logic [31:0] value,
  output logic        sign,
  output logic [7:0]  exp_field,
  output logic [22:0] frac,
  output logic        is_zero,
  output logic        is_denorm,
  output logic        is_inf,
  output logic        is_nan
);
  fp32_t f;

  assign f         = value;
  assign sign      = f.sign;
  assign exp_field = f.exp;
  assign frac      = f.frac;
  assign is_zero   = (f.exp == '0) && (f.frac == '0);
  assign is_denorm = (f.exp == '0) && (f.frac != '0);
  assign is_inf    = (f.exp == EXP_MAX) && (f.frac == '0);
  assign is_nan    = (f.exp == EXP_MAX) && (f.frac != '0);
endmodule

// File: rtl/fp_adder.sv
// Multi-cycle binary32 adder: bit-serial alignment and normalization, round-to-nearest-even.
module fp_adder import fpu_pkg::*; (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] a_value_i,
  input  logic [31:0] b_value_i,
  output logic [31:0] z_value_o,
  input  logic        exec_strobe_i,
  output logic        done_strobe_o
);
  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL_CASES, ALIGN, ADD_0, ADD_1,
    NORMALIZE_0, NORMALIZE_1, ROUND, PACK, DONE
  } state_t;

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);
  localparam logic signed [9:0] EMIN_S = 10'(EMIN);

  state_t state, state_next;

  logic               ua_sign, ub_sign;
  logic [7:0]         ua_exp, ub_exp;
  logic [22:0]        ua_frac, ub_frac;
  logic               ua_zero, ua_den, ua_inf, ua_nan;
  logic               ub_zero, ub_den, ub_inf, ub_nan;

  logic [31:0]        a_word, b_word;
  logic               a_s, b_s, a_zero, b_zero, a_den, b_den, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0]  a_e, b_e, z_e;
  logic [26:0]        a_m, b_m;
  logic [27:0]        sum;
  logic [23:0]        z_m;
  logic               z_s, guard, round_bit, sticky;
  logic [31:0]        z_res;
  logic               done_next;

  logic signed [9:0]  diff_ab, diff_ba;
  logic [7:0]         z_field;
  logic               special;

  fp_unpack u_unpack_a (
    .value(a_value_i), .sign(ua_sign), .exp_field(ua_exp), .frac(ua_frac),
    .is_zero(ua_zero), .is_denorm(ua_den), .is_inf(ua_inf), .is_nan(ua_nan)
  );

  fp_unpack u_unpack_b (
    .value(b_value_i), .sign(ub_sign), .exp_field(ub_exp), .frac(ub_frac),
    .is_zero(ub_zero), .is_denorm(ub_den), .is_inf(ub_inf), .is_nan(ub_nan)
  );

  function automatic logic round_up(input logic g, input logic r, input logic s, input logic lsb);
    return g & (r | s | lsb);
  endfunction

  // Right shift by one that folds the lost bit into the sticky position.
  function automatic logic [26:0] shr_sticky(input logic [26:0] m);
    return {1'b0, m[26:2], m[1] | m[0]};
  endfunction

  assign diff_ab = a_e - b_e;
  assign diff_ba = b_e - a_e;
  // Modulo-256 add gives the biased field for every in-range exponent.
  assign z_field = z_e[7:0] + 8'd127;
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_ff @(posedge clk) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (exec_strobe_i && !done_strobe_o) state_next = UNPACK;
      UNPACK:        state_next = SPECIAL_CASES;
      SPECIAL_CASES: state_next = special ? DONE : ALIGN;
      ALIGN:         if (a_e == b_e) state_next = ADD_0;
      ADD_0:         state_next = ADD_1;
      ADD_1:         state_next = (sum == '0) ? PACK : NORMALIZE_0;
      NORMALIZE_0:   if (z_m[23] || (z_e <= EMIN_S)) state_next = NORMALIZE_1;
      NORMALIZE_1:   if (z_e >= EMIN_S) state_next = ROUND;
      ROUND:         state_next = PACK;
      PACK:          state_next = DONE;
      DONE:          state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    done_next = 1'b0;
    if (state == DONE) done_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      done_strobe_o <= 1'b0;
      z_value_o     <= '0;
    end else begin
      done_strobe_o <= done_next;
      if (done_next) z_value_o <= z_res;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      UNPACK: begin
        a_word <= a_value_i;
        b_word <= b_value_i;
        a_s    <= ua_sign;
        b_s    <= ub_sign;
        a_e    <= $signed({2'b00, ua_exp}) - BIAS_S;
        b_e    <= $signed({2'b00, ub_exp}) - BIAS_S;
        a_m    <= {1'b0, ua_frac, 3'b000};
        b_m    <= {1'b0, ub_frac, 3'b000};
        a_zero <= ua_zero;
        b_zero <= ub_zero;
        a_den  <= ua_den;
        b_den  <= ub_den;
        a_inf  <= ua_inf;
        b_inf  <= ub_inf;
        a_nan  <= ua_nan;
        b_nan  <= ub_nan;
      end
      SPECIAL_CASES: begin
        if (a_nan || b_nan)                      z_res <= CANON_NAN;
        else if (a_inf && b_inf && (a_s != b_s)) z_res <= CANON_NAN;
        else if (a_inf)                          z_res <= {a_s, EXP_MAX, 23'd0};
        else if (b_inf)                          z_res <= {b_s, EXP_MAX, 23'd0};
        else if (a_zero && b_zero)               z_res <= {a_s & b_s, 31'd0};
        else if (a_zero)                         z_res <= b_word;
        else if (b_zero)                         z_res <= a_word;
        else begin
          if (a_den) a_e <= EMIN_S;
          else       a_m[26] <= 1'b1;
          if (b_den) b_e <= EMIN_S;
          else       b_m[26] <= 1'b1;
        end
      end
      ALIGN: begin
        if (a_e > b_e) begin
          if (diff_ab > 10'sd26) begin
            b_m <= 27'd1;
            b_e <= a_e;
          end else begin
            b_m <= shr_sticky(b_m);
            b_e <= b_e + 10'sd1;
          end
        end else if (b_e > a_e) begin
          if (diff_ba > 10'sd26) begin
            a_m <= 27'd1;
            a_e <= b_e;
          end else begin
            a_m <= shr_sticky(a_m);
            a_e <= a_e + 10'sd1;
          end
        end
      end
      ADD_0: begin
        z_e <= a_e;
        if (a_s == b_s) begin
          sum <= {1'b0, a_m} + {1'b0, b_m};
          z_s <= a_s;
        end else if (a_m >= b_m) begin
          sum <= {1'b0, a_m} - {1'b0, b_m};
          z_s <= a_s;
        end else begin
          sum <= {1'b0, b_m} - {1'b0, a_m};
          z_s <= b_s;
        end
      end
      ADD_1: begin
        if (sum == '0) begin
          z_s       <= 1'b0;
          z_m       <= '0;
          z_e       <= EMIN_S;
          guard     <= 1'b0;
          round_bit <= 1'b0;
          sticky    <= 1'b0;
        end else if (sum[27]) begin
          z_m       <= sum[27:4];
          guard     <= sum[3];
          round_bit <= sum[2];
          sticky    <= sum[1] | sum[0];
          z_e       <= z_e + 10'sd1;
        end else begin
          z_m       <= sum[26:3];
          guard     <= sum[2];
          round_bit <= sum[1];
          sticky    <= sum[0];
        end
      end
      NORMALIZE_0: begin
        if (!z_m[23] && (z_e > EMIN_S)) begin
          z_e       <= z_e - 10'sd1;
          z_m       <= {z_m[22:0], guard};
          guard     <= round_bit;
          round_bit <= 1'b0;
        end
      end
      NORMALIZE_1: begin
        if (z_e < EMIN_S) begin
          z_e       <= z_e + 10'sd1;
          z_m       <= {1'b0, z_m[23:1]};
          guard     <= z_m[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
        end
      end
      ROUND: begin
        if (round_up(guard, round_bit, sticky, z_m[0])) begin
          z_m <= z_m + 24'd1;
          if (&z_m) z_e <= z_e + 10'sd1;
        end
      end
      PACK: begin
        if (z_e > 10'sd127)                    z_res <= {z_s, EXP_MAX, 23'd0};
        else if ((z_e == EMIN_S) && !z_m[23])  z_res <= {z_s, 8'd0, z_m[22:0]};
        else                                   z_res <= {z_s, z_field, z_m[22:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fp_adder.sv
// Bench for fp_adder: directed vectors, latency and handshake checks, randomized ops vs an exact-arithmetic model.
module tb_fp_adder;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] a_value_i, b_value_i, z_value_o;
  logic        exec_strobe_i, done_strobe_o;

  int total  = 0;
  int passed = 0;

  logic [31:0] specials [0:5];

  always #5 clk = ~clk;

  fp_adder dut (
    .clk(clk), .reset_i(reset_i), .a_value_i(a_value_i), .b_value_i(b_value_i),
    .z_value_o(z_value_o), .exec_strobe_i(exec_strobe_i), .done_strobe_o(done_strobe_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Exact sum on a common 2^-149 grid, then a single RNE rounding to binary32.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [319:0] va, vb, mag, q, rem, half, one;
    logic         neg, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    int           ka, kb, kmin, p, t, drop, field;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
    if (a_nan || b_nan) return 32'hFFC00000;
    if (a_inf && b_inf && (a[31] != b[31])) return 32'hFFC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    one  = 1;
    ka   = (a[30:23] == 0) ? 0 : int'(a[30:23]) - 1;
    kb   = (b[30:23] == 0) ? 0 : int'(b[30:23]) - 1;
    kmin = (ka < kb) ? ka : kb;
    va   = 320'({(a[30:23] != 0), a[22:0]}) << (ka - kmin);
    vb   = 320'({(b[30:23] != 0), b[22:0]}) << (kb - kmin);
    if (a[31] == b[31]) begin mag = va + vb; neg = a[31]; end
    else if (va >= vb)  begin mag = va - vb; neg = a[31]; end
    else                begin mag = vb - va; neg = b[31]; end
    if (mag == 0) return 32'h00000000;
    p = -1;
    for (int i = 319; i >= 0; i--) if (p < 0 && mag[i]) p = i;
    t = p + kmin - 149 - 23;
    if (t < -149) t = -149;
    drop = t - (kmin - 149);
    if (drop <= 0) q = mag << (-drop);
    else begin
      q    = mag >> drop;
      rem  = mag & ((one << drop) - one);
      half = one << (drop - 1);
      if (rem > half || (rem == half && q[0])) q = q + one;
    end
    if (q[24]) begin q = q >> 1; t++; end
    if (!q[23]) return {neg, 8'd0, q[22:0]};
    field = t + 150;
    if (field >= 255) return {neg, 8'hFF, 23'd0};
    return {neg, field[7:0], q[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_z,
                       input int exp_cyc, input string tag);
    int   cyc;
    logic seen;
    @(negedge clk);
    a_value_i = a;
    b_value_i = b;
    exec_strobe_i = 1'b1;
    @(posedge clk);
    #1 exec_strobe_i = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = done_strobe_o;
    end
    check_eq({tag, " done"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, " z"}, z_value_o, exp_z);
      if (exp_cyc >= 0) check_eq({tag, " cycles"}, cyc, exp_cyc);
      @(negedge clk);
      check_eq({tag, " pulse"}, 32'(done_strobe_o), 32'd0);
      check_eq({tag, " held"}, z_value_o, exp_z);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, r1, r2;
    int          e, ndone, hold_n;

    specials[0] = 32'h00000000; specials[1] = 32'h80000000; specials[2] = 32'h7F800000;
    specials[3] = 32'hFF800000; specials[4] = 32'h7FC00000; specials[5] = 32'h7F7FFFFF;

    reset_i = 1'b1; exec_strobe_i = 1'b0; a_value_i = '0; b_value_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset done", 32'(done_strobe_o), 32'd0);
    check_eq("reset z", z_value_o, 32'h0);
    reset_i = 1'b0;

    do_op(32'h3F800000, 32'h3F800000, 32'h40000000, 11, "1+1");
    do_op(32'h3F800000, 32'hBF800000, 32'h00000000, -1, "1-1");
    do_op(32'h7F800000, 32'hFF800000, 32'hFFC00000, 4,  "inf-inf");
    do_op(32'h7FC00000, 32'h3F800000, 32'hFFC00000, 4,  "nan+1");
    do_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 4,  "inf+1");
    do_op(32'h3F800000, 32'h33800000, 32'h3F800000, 35, "tie even");
    do_op(32'h3F800001, 32'h33800000, 32'h3F800002, 35, "tie odd");
    do_op(32'h3F800000, 32'h30800000, 32'h3F800000, 12, "collapse");
    do_op(32'h00000001, 32'h00000001, 32'h00000002, 11, "denorm add");
    do_op(32'h00800000, 32'h80000001, 32'h007FFFFF, 11, "denorm sub");
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 11, "overflow");
    do_op(32'h80000000, 32'h80000000, 32'h80000000, 4,  "neg zeros");
    do_op(32'h00000000, 32'hC0490FDB, 32'hC0490FDB, 4,  "zero+b");

    // Abort an operation while it is still aligning.
    @(negedge clk);
    a_value_i = 32'h3F800000; b_value_i = 32'h33800000; exec_strobe_i = 1'b1;
    @(posedge clk);
    #1 exec_strobe_i = 1'b0;
    repeat (5) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check_eq("abort done", 32'(done_strobe_o), 32'd0);
    check_eq("abort z", z_value_o, 32'h0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_strobe_o) ndone++;
    end
    check_eq("abort no pulse", ndone, 0);
    do_op(32'h3F800000, 32'h40000000, 32'h40400000, 12, "after abort");

    // Strobe held high: one pulse per accepted start, next start the cycle after each pulse.
    hold_n = 60;
    ndone  = 0;
    @(negedge clk);
    a_value_i = 32'h3F800000; b_value_i = 32'h3F800000; exec_strobe_i = 1'b1;
    for (int i = 0; i < hold_n + 20; i++) begin
      @(negedge clk);
      if (i == hold_n - 1) exec_strobe_i = 1'b0;
      if (done_strobe_o) begin
        ndone++;
        check_eq("hold z", z_value_o, 32'h40000000);
      end
    end
    check_eq("hold pulses", ndone, (hold_n + 11) / 12);

    for (int i = 0; i < 250; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      case ($urandom_range(0, 7))
        0:       ra = {r1[31], 8'd0, r1[22:0]};
        1:       ra = specials[$urandom_range(0, 5)];
        2:       ra = r1;
        default: ra = {r1[31], 8'($urandom_range(110, 145)), r1[22:0]};
      endcase
      case ($urandom_range(0, 5))
        0:       rb = (r2[30]) ? r2 : {r2[31], 8'd0, r2[22:0]};
        1:       rb = {~ra[31], ra[30:0] ^ {27'd0, r2[3:0]}};
        2:       rb = specials[$urandom_range(0, 5)];
        default: begin
          e = int'(ra[30:23]) + int'($urandom_range(0, 60)) - 30;
          if (e < 0) e = 0;
          if (e > 254) e = 254;
          rb = {r2[31], e[7:0], r2[22:0]};
        end
      endcase
      do_op(ra, rb, ref_add(ra, rb), -1, $sformatf("rand%0d %h+%h", i, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
